rapcore_spi_bridge: RTL and testbench

Wishbone-to-SPI bridge and arbiter that allows the management SoC to configure and command `rapcore` over its SPI slave port (SCK/CS/COPI/CIPO). It shares that port with the external SPI pads: whichever side claims the bus first owns it until its transaction ends. The block sits in `user_project_wrapper` between the Wishbone slave port, the IO pads and `rapcore`. It serialises 64-bit command words, MSB first, in SPI mode 0 and captures the 64-bit reply.

---
 rtl/rapcore_bridge_pkg.sv | 47 ++++
 rtl/rapcore_spi_shifter.sv | 62 ++++++
 rtl/rapcore_spi_bridge.sv | 192 +++++++++++++++++++
 tb/tb_rapcore_spi_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapcore_bridge_pkg.sv
// Shared types and constants for the rapcore Wishbone-to-SPI bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rapcore_bridge_pkg;

    localparam int WORD_W_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_SETUP,
        ST_SCK_HI,
        ST_SCK_LO,
        ST_TRAIL,
        ST_HOLD
    } state_t;

    localparam logic [2:0] REG_TXLO   = 3'd0;
    localparam logic [2:0] REG_TXHI   = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_RXLO   = 3'd4;
    localparam logic [2:0] REG_RXHI   = 3'd5;

    localparam int CTRL_START    = 0;
    localparam int CTRL_HOLD     = 1;
    localparam int CTRL_RELEASE  = 2;
    localparam int CTRL_CLR_COLL = 3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EXT_OWNER = 1;
    localparam int STAT_CS_ACTIVE = 2;
    localparam int STAT_RX_VALID  = 3;
    localparam int STAT_COLLISION = 4;
    localparam int STAT_PENDING   = 5;

    function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rapcore_spi_shifter.sv
// SPI datapath: tx/rx shift registers, bit counter and SCK half-period counter.
// Latency: shifts/loads take effect on the clock edge the controlling strobe is high.
// Backpressure: none; the arbiter FSM sequences every strobe.
module rapcore_spi_shifter #(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              load,
    input  logic              shift_rx,
    input  logic              shift_tx,
    input  logic              cipo,
    input  logic [WORD_W-1:0] tx_word,
    output logic              tx_msb,
    output logic [WORD_W-1:0] rx_word,
    output logic              div_done,
    output logic              last_bit
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(WORD_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] tx_sr;

    assign div_done = (div_cnt == DIV_MAX);
    assign last_bit = (bit_cnt == BIT_MAX);
    assign tx_msb   = tx_sr[WORD_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_word <= '0;
        end else begin
            // Saturate so the counter idles quietly between phases.
            if (restart)
                div_cnt <= '0;
            else if (!div_done)
                div_cnt <= div_cnt + DIV_W'(1);

            if (load) begin
                tx_sr   <= tx_word;
                rx_word <= '0;
                bit_cnt <= '0;
            end else begin
                if (shift_rx) begin
                    rx_word <= {rx_word[WORD_W-2:0], cipo};
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
                if (shift_tx && !last_bit)
                    tx_sr <= {tx_sr[WORD_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/rapcore_spi_bridge.sv
// Wishbone-to-SPI bridge sharing rapcore's SPI slave port with the external pads.
// Latency: Wishbone ack one cycle after stb&cyc; one word is (2*WORD_W+2)*CLK_DIV cycles.
// Backpressure: first side to claim the SPI bus owns it; an internal start made while the pads own it is held pending.
module rapcore_spi_bridge
    import rapcore_bridge_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        ext_sck_i,
    input  logic        ext_cs_i,
    input  logic        ext_copi_i,
    output logic        ext_cipo_o,
    output logic        sck_o,
    output logic        cs_o,
    output logic        copi_o,
    input  logic        cipo_i,
    output logic        done_o
);
    state_t            state, nstate;
    logic              ack;
    logic [31:0]       tx_lo, tx_hi, rdat;
    logic [WORD_W-1:0] rx_reg, sh_rx;
    logic              rx_valid, collision, pending, hold_r;
    logic              cs_s1, cs_s2, cs_d;
    logic              div_done, last_bit, tx_msb;

    logic       bus_req, wr, rd, ctrl_wr, start_wr, release_wr, clr_coll_wr, start_ok;
    logic       ext_low, cs_fall, busy;
    logic [2:0] idx;
    logic       unused_adr;

    assign bus_req     = wbs_stb_i & wbs_cyc_i & ~ack;
    assign wr          = bus_req & wbs_we_i;
    assign rd          = bus_req & ~wbs_we_i;
    assign idx         = wbs_adr_i[4:2];
    assign unused_adr  = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
    assign ctrl_wr     = wr && (idx == REG_CTRL) && wbs_sel_i[0];
    assign start_wr    = ctrl_wr & wbs_dat_i[CTRL_START];
    assign release_wr  = ctrl_wr & wbs_dat_i[CTRL_RELEASE];
    assign clr_coll_wr = ctrl_wr & wbs_dat_i[CTRL_CLR_COLL];
    assign start_ok    = start_wr & (state inside {ST_IDLE, ST_EXT, ST_HOLD});
    assign ext_low     = ~cs_s2;
    assign cs_fall     = cs_d & ~cs_s2;
    assign busy        = state inside {ST_SETUP, ST_SCK_HI, ST_SCK_LO, ST_TRAIL};
    assign wbs_ack_o   = ack;

    // External claim wins a same-cycle race with an internal start.
    always_comb begin
        nstate     = state;
        sck_o      = 1'b0;
        cs_o       = 1'b1;
        copi_o     = 1'b0;
        ext_cipo_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ext_low)                  nstate = ST_EXT;
                else if (start_wr || pending) nstate = ST_SETUP;
            end
            ST_EXT: begin
                sck_o      = ext_sck_i;
                cs_o       = ext_cs_i;
                copi_o     = ext_copi_i;
                ext_cipo_o = cipo_i;
                if (!ext_low) nstate = ST_IDLE;
            end
            ST_SETUP: begin
                cs_o   = 1'b0;
                copi_o = tx_msb;
                if (div_done) nstate = ST_SCK_HI;
            end
            ST_SCK_HI: begin
                cs_o   = 1'b0;
                sck_o  = 1'b1;
                copi_o = tx_msb;
                if (div_done) nstate = ST_SCK_LO;
            end
            ST_SCK_LO: begin
                cs_o   = 1'b0;
                copi_o = tx_msb;
                if (div_done) nstate = last_bit ? ST_TRAIL : ST_SCK_HI;
            end
            ST_TRAIL: begin
                cs_o   = 1'b0;
                copi_o = tx_msb;
                if (div_done) nstate = hold_r ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                cs_o = 1'b0;
                if (start_wr)        nstate = ST_SETUP;
                else if (release_wr) nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    always_comb begin
        rdat = '0;
        case (idx)
            REG_TXLO:   rdat = tx_lo;
            REG_TXHI:   rdat = tx_hi;
            REG_STATUS: begin
                rdat[STAT_BUSY]      = busy;
                rdat[STAT_EXT_OWNER] = (state == ST_EXT);
                rdat[STAT_CS_ACTIVE] = ~cs_o;
                rdat[STAT_RX_VALID]  = rx_valid;
                rdat[STAT_COLLISION] = collision;
                rdat[STAT_PENDING]   = pending;
            end
            REG_RXLO:   rdat = rx_reg[31:0];
            REG_RXHI:   rdat = rx_reg[63:32];
            default:    rdat = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state     <= ST_IDLE;
            ack       <= 1'b0;
            wbs_dat_o <= '0;
            tx_lo     <= '0;
            tx_hi     <= '0;
            rx_reg    <= '0;
            rx_valid  <= 1'b0;
            collision <= 1'b0;
            pending   <= 1'b0;
            hold_r    <= 1'b0;
            done_o    <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_d      <= 1'b1;
        end else begin
            state     <= nstate;
            ack       <= bus_req;
            wbs_dat_o <= rd ? rdat : '0;
            cs_s1     <= ext_cs_i;
            cs_s2     <= cs_s1;
            cs_d      <= cs_s2;

            if (wr && idx == REG_TXLO) tx_lo <= apply_sel(tx_lo, wbs_dat_i, wbs_sel_i);
            if (wr && idx == REG_TXHI) tx_hi <= apply_sel(tx_hi, wbs_dat_i, wbs_sel_i);
            if (start_ok) hold_r <= wbs_dat_i[CTRL_HOLD];

            if (state == ST_IDLE && nstate == ST_SETUP)
                pending <= 1'b0;
            else if (start_wr && (state == ST_EXT || (state == ST_IDLE && ext_low)))
                pending <= 1'b1;

            if (cs_fall && state != ST_IDLE && state != ST_EXT)
                collision <= 1'b1;
            else if (clr_coll_wr)
                collision <= 1'b0;

            done_o <= (state == ST_TRAIL) && div_done;
            if (state == ST_TRAIL && div_done) begin
                rx_reg   <= sh_rx;
                rx_valid <= 1'b1;
            end else if (rd && idx == REG_RXHI) begin
                rx_valid <= 1'b0;
            end
        end
    end

    rapcore_spi_shifter #(
        .CLK_DIV (CLK_DIV),
        .WORD_W  (WORD_W)
    ) u_shifter (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .restart  (nstate != state),
        .load     (nstate == ST_SETUP && state != ST_SETUP),
        .shift_rx (nstate == ST_SCK_HI && state != ST_SCK_HI),
        .shift_tx (nstate == ST_SCK_LO && state == ST_SCK_HI),
        .cipo     (cipo_i),
        .tx_word  ({tx_hi, tx_lo}),
        .tx_msb   (tx_msb),
        .rx_word  (sh_rx),
        .div_done (div_done),
        .last_bit (last_bit)
    );

endmodule

// File: tb/tb_rapcore_spi_bridge.sv
// Bench for rapcore_spi_bridge at CLK_DIV=2: register vector table, then SPI word,
// hold frame, external ownership, collision and mid-word reset sequences.
// A behavioural SPI slave feeds cipo_i; copi bits and read data are scoreboarded.
module tb_rapcore_spi_bridge;

    logic        clk = 1'b0;
    logic        wb_rst_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ext_sck_i, ext_cs_i, ext_copi_i, ext_cipo_o;
    logic        sck_o, cs_o, copi_o, cipo_i, done_o;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int cs_fall_cyc = 0;
    int bits_sent   = 0;
    bit cs_rose     = 0;
    logic sck_prev  = 1'b0;
    logic cs_prev   = 1'b1;
    logic [63:0] slave_sr = '0;
    logic        copi_q[$];
    logic [31:0] rd_q[$];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    assign cipo_i = slave_sr[63];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rapcore_spi_bridge #(.CLK_DIV(2), .WORD_W(64)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (wb_rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ext_sck_i  (ext_sck_i),
        .ext_cs_i   (ext_cs_i),
        .ext_copi_i (ext_copi_i),
        .ext_cipo_o (ext_cipo_o),
        .sck_o      (sck_o),
        .cs_o       (cs_o),
        .copi_o     (copi_o),
        .cipo_i     (cipo_i),
        .done_o     (done_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, output logic [31:0] rdat);
        int n;
        @(negedge clk);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack_o && n < 20);
        if (!wbs_ack_o) timeout("wb_ack");
        rdat = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        wb_cycle(1'b1, adr, 4'hF, dat, d);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        rd_q.push_back(exp);
        wb_cycle(1'b0, adr, 4'hF, 32'h0, d);
        check(name, 64'(d), 64'(rd_q.pop_front()));
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) timeout(name);
    endtask

    task automatic wait_bits(input int target);
        int n = 0;
        while (bits_sent < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (bits_sent < target) timeout("wait_bits");
    endtask

    task automatic push_tx(input logic [63:0] w);
        for (int i = 63; i >= 0; i--) copi_q.push_back(w[i]);
    endtask

    // SPI slave model and copi scoreboard, evaluated between clock edges.
    always @(negedge clk) begin
        if (!wb_rst_n) begin
            sck_prev  = 1'b0;
            cs_prev   = 1'b1;
            bits_sent = 0;
        end else begin
            if (cs_prev && !cs_o) cs_fall_cyc = cyc;
            if (!cs_prev && cs_o) cs_rose = 1'b1;
            if (cs_o) bits_sent = 0;
            if (sck_o && !sck_prev) begin
                bits_sent++;
                slave_sr = {slave_sr[62:0], 1'b0};
                if (copi_q.size() > 0) check("copi_bit", 64'(copi_o), 64'(copi_q.pop_front()));
            end
            sck_prev = sck_o;
            cs_prev  = cs_o;
        end
    end

    initial begin
        int n;
        int dur;
        logic [31:0] d;

        vecs[0]  = '{1'b0, 32'h0C, 4'hF, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 32'h00, 4'hF, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 32'h14, 4'hF, 32'h0,        32'h0};
        vecs[3]  = '{1'b1, 32'h00, 4'hF, 32'h01234567, 32'h0};
        vecs[4]  = '{1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b0, 32'h00, 4'hF, 32'h0,        32'h01234567};
        vecs[6]  = '{1'b0, 32'h04, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[7]  = '{1'b1, 32'h00, 4'h1, 32'hAAAAAA99, 32'h0};
        vecs[8]  = '{1'b0, 32'h00, 4'hF, 32'h0,        32'h01234599};
        vecs[9]  = '{1'b1, 32'h00, 4'hF, 32'h01234567, 32'h0};
        vecs[10] = '{1'b1, 32'h1C, 4'hF, 32'hFFFFFFFF, 32'h0};
        vecs[11] = '{1'b0, 32'h1C, 4'hF, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h00, 4'hF, 32'h0,        32'h01234567};
        vecs[13] = '{1'b0, 32'h18, 4'hF, 32'h0,        32'h0};

        wb_rst_n = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
        ext_sck_i = 1'b0; ext_cs_i = 1'b1; ext_copi_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs",   64'(cs_o), 64'(1));
        check("rst_sck",  64'(sck_o), 64'(0));
        check("rst_copi", 64'(copi_o), 64'(0));
        check("rst_cipo", 64'(ext_cipo_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_ack",  64'(wbs_ack_o), 64'(0));
        check("rst_dat",  64'(wbs_dat_o), 64'(0));
        wb_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) wb_cycle(1'b1, vecs[i].adr, vecs[i].sel, vecs[i].dat, d);
            else rd_chk($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);
        end

        // Single word; second start while busy (with hold) must be ignored.
        slave_sr = 64'hA5A5_0000_FFFF_1234;
        push_tx(64'hDEAD_BEEF_0123_4567);
        wr(32'h08, 32'h1);
        check("cs_with_ack", 64'(cs_o), 64'(0));
        rd_chk("stat_busy", 32'h0C, 32'h05);
        wr(32'h08, 32'h3);
        wait_done("single_done");
        dur = cyc - cs_fall_cyc;
        check("word_cycles", 64'(dur), 64'(260));
        check("cs_up_after", 64'(cs_o), 64'(1));
        @(negedge clk);
        check("done_pulse", 64'(done_o), 64'(0));
        rd_chk("stat_rxv", 32'h0C, 32'h08);
        rd_chk("rxlo", 32'h10, 32'hFFFF_1234);
        rd_chk("rxhi", 32'h14, 32'hA5A5_0000);
        rd_chk("stat_clr", 32'h0C, 32'h00);
        check("copi_all", 64'(copi_q.size()), 64'(0));

        // Hold frame: two held words, then release.
        wr(32'h08, 32'h3);
        cs_rose = 1'b0;
        wait_done("hold1_done");
        check("hold_cs", 64'(cs_o), 64'(0));
        rd_chk("stat_hold", 32'h0C, 32'h0C);
        wr(32'h08, 32'h3);
        wait_done("hold2_done");
        @(negedge clk);
        check("frame_cs_low", 64'(cs_rose), 64'(0));
        wr(32'h08, 32'h4);
        @(negedge clk);
        check("release_cs", 64'(cs_o), 64'(1));
        rd_chk("hold_rxhi", 32'h14, 32'h0);

        // External ownership with a pending internal start.
        @(negedge clk);
        ext_cs_i = 1'b0;
        repeat (4) @(negedge clk);
        rd_chk("stat_ext", 32'h0C, 32'h06);
        wr(32'h08, 32'h1);
        rd_chk("stat_pend", 32'h0C, 32'h26);
        ext_sck_i = 1'b1; ext_copi_i = 1'b1;
        #1;
        check("ext_sck_hi", 64'(sck_o), 64'(1));
        check("ext_copi", 64'(copi_o), 64'(1));
        @(negedge clk);
        ext_sck_i = 1'b0;
        slave_sr = '1;
        #1;
        check("ext_sck_lo", 64'(sck_o), 64'(0));
        check("ext_cipo", 64'(ext_cipo_o), 64'(1));
        @(negedge clk);
        ext_cs_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cs_o && n < 20);
        check("pend_launch", 64'(n >= 3 && n <= 4), 64'(1));
        wait_done("pend_done");
        wb_cycle(1'b0, 32'h14, 4'hF, 32'h0, d);

        // Collision mid-word.
        wr(32'h00, 32'h4B5A_6978);
        wr(32'h04, 32'h0F1E_2D3C);
        slave_sr = 64'hFFFF_FFF0_5A5A_C3C3;
        push_tx(64'h0F1E_2D3C_4B5A_6978);
        wr(32'h08, 32'h1);
        wait_bits(8);
        ext_cs_i = 1'b0;
        ext_sck_i = 1'b1;
        repeat (6) @(negedge clk);
        check("coll_cipo", 64'(ext_cipo_o), 64'(0));
        rd_chk("stat_coll", 32'h0C, 32'h15);
        ext_cs_i = 1'b1;
        ext_sck_i = 1'b0;
        wait_done("coll_done");
        rd_chk("coll_rxlo", 32'h10, 32'h5A5A_C3C3);
        rd_chk("coll_rxhi", 32'h14, 32'hFFFF_FFF0);
        rd_chk("coll_stat", 32'h0C, 32'h10);
        wr(32'h08, 32'h8);
        rd_chk("coll_clr", 32'h0C, 32'h00);

        // Reset part-way through a word.
        wr(32'h08, 32'h1);
        wait_bits(34);
        wb_rst_n = 1'b0;
        #1;
        check("rst_mid_cs", 64'(cs_o), 64'(1));
        check("rst_mid_sck", 64'(sck_o), 64'(0));
        repeat (2) @(negedge clk);
        wb_rst_n = 1'b1;
        rd_chk("post_txlo", 32'h00, 32'h0);
        rd_chk("post_txhi", 32'h04, 32'h0);
        rd_chk("post_rxlo", 32'h10, 32'h0);
        rd_chk("post_rxhi", 32'h14, 32'h0);
        rd_chk("post_stat", 32'h0C, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
